coriolis_fpmul_arbiter: RTL and testbench

Shares one pipelined FloPoCo FP32 multiplier among NREQ stream requesters in the coriolis kernel datapath. A round-robin scheduler grants one operand pair per cycle. A tag pipeline matched to the multiplier latency routes each result back to the requester that issued it. Back-pressure from the addressed consumer freezes the multiplier through its `stall` input.

---
 rtl/coriolis_fpmul_arbiter.sv | 109 ++++++++++
 tb/tb_coriolis_fpmul_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coriolis_fpmul_arbiter.sv
// Shares one pipelined FP32 multiplier among NREQ streams: round-robin issue,
// a tag pipeline matched to the multiplier latency, and consumer back-pressure.
module coriolis_fpmul_arbiter #(
    parameter int STREAMW = 34,
    parameter int NREQ    = 4,
    parameter int MUL_LAT = 3,
    parameter int IDXW    = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CNTW   = $clog2(MUL_LAT + 1)
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [NREQ-1:0]           i_req_valid,
    output logic [NREQ-1:0]           o_req_ready,
    input  logic [NREQ*STREAMW-1:0]   i_req_x,
    input  logic [NREQ*STREAMW-1:0]   i_req_y,
    output logic [STREAMW-1:0]        o_mul_x,
    output logic [STREAMW-1:0]        o_mul_y,
    output logic                      o_mul_stall,
    input  logic [STREAMW-1:0]        i_mul_r,
    output logic [NREQ-1:0]           o_rsp_valid,
    output logic [STREAMW-1:0]        o_rsp_data,
    input  logic [NREQ-1:0]           i_rsp_ready,
    output logic [CNTW-1:0]           o_inflight
);

    localparam int TAIL = MUL_LAT - 1;

    logic [MUL_LAT-1:0] r_tag_v;
    logic [IDXW-1:0]    r_tag_idx [MUL_LAT];
    logic [IDXW-1:0]    r_ptr;
    logic [STREAMW-1:0] r_last_x;
    logic [STREAMW-1:0] r_last_y;
    logic [CNTW-1:0]    r_inflight;

    logic               w_hold;
    logic               w_adv;
    logic               w_any;
    logic               w_issue;
    logic [IDXW-1:0]    w_grant;
    logic [MUL_LAT-1:0] w_tag_v_nxt;
    logic [CNTW-1:0]    w_cnt_nxt;

    function automatic logic [IDXW-1:0] f_rot(input logic [IDXW-1:0] base, input int step);
        int s;
        s = int'(base) + step;
        if (s >= NREQ) s = s - NREQ;
        return IDXW'(s);
    endfunction

    assign w_hold = r_tag_v[TAIL] & ~i_rsp_ready[r_tag_idx[TAIL]];
    assign w_adv  = ~w_hold;

    always_comb begin
        w_any   = 1'b0;
        w_grant = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_any && i_req_valid[f_rot(r_ptr, k)]) begin
                w_any   = 1'b1;
                w_grant = f_rot(r_ptr, k);
            end
        end
    end

    // Reset gates issue combinationally so nothing is offered while rst is low.
    assign w_issue = w_any & i_rst_n;

    assign o_req_ready = (w_issue && w_adv) ? (NREQ'(1) << w_grant) : '0;
    assign o_mul_x     = w_issue ? i_req_x[w_grant*STREAMW +: STREAMW] : r_last_x;
    assign o_mul_y     = w_issue ? i_req_y[w_grant*STREAMW +: STREAMW] : r_last_y;
    assign o_mul_stall = w_hold;

    always_comb begin
        w_tag_v_nxt    = '0;
        w_tag_v_nxt[0] = w_issue;
        for (int i = 1; i < MUL_LAT; i++) begin
            w_tag_v_nxt[i] = r_tag_v[i-1];
        end
        w_cnt_nxt = '0;
        for (int i = 0; i < MUL_LAT; i++) begin
            w_cnt_nxt = w_cnt_nxt + CNTW'(w_tag_v_nxt[i]);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tag_v    <= '0;
            for (int i = 0; i < MUL_LAT; i++) r_tag_idx[i] <= '0;
            r_ptr      <= '0;
            r_last_x   <= '0;
            r_last_y   <= '0;
            r_inflight <= '0;
        end else if (w_adv) begin
            r_tag_v      <= w_tag_v_nxt;
            r_tag_idx[0] <= w_grant;
            for (int i = 1; i < MUL_LAT; i++) r_tag_idx[i] <= r_tag_idx[i-1];
            r_inflight   <= w_cnt_nxt;
            if (w_issue) begin
                r_ptr    <= f_rot(w_grant, 1);
                r_last_x <= i_req_x[w_grant*STREAMW +: STREAMW];
                r_last_y <= i_req_y[w_grant*STREAMW +: STREAMW];
            end
        end
    end

    assign o_rsp_valid = r_tag_v[TAIL] ? (NREQ'(1) << r_tag_idx[TAIL]) : '0;
    assign o_rsp_data  = i_mul_r;
    assign o_inflight  = r_inflight;

endmodule

// File: tb/tb_coriolis_fpmul_arbiter.sv
// Bench for coriolis_fpmul_arbiter: behavioural FP multiplier plus a queue-based
// reference model of issue order, latency and back-pressure.
module tb_coriolis_fpmul_arbiter;
    localparam int W    = 34;
    localparam int NREQ = 4;
    localparam int LAT  = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [NREQ-1:0]   vld, rdy, ready, rsp_valid;
    logic [NREQ*W-1:0] xs, ys;
    logic [W-1:0]      mul_x, mul_y, mul_r, rsp_data;
    logic              stall;
    logic [1:0]        inflight;
    int total = 0;
    int bad   = 0;

    coriolis_fpmul_arbiter #(.STREAMW(W), .NREQ(NREQ), .MUL_LAT(LAT)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(vld), .o_req_ready(ready),
        .i_req_x(xs), .i_req_y(ys),
        .o_mul_x(mul_x), .o_mul_y(mul_y), .o_mul_stall(stall),
        .i_mul_r(mul_r),
        .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data), .i_rsp_ready(rdy),
        .o_inflight(inflight)
    );

    // Normal-number FP32 multiply (truncating), exception field forced to "normal".
    function automatic logic [W-1:0] fpmul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [47:0] p;
        int e;
        p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) return {2'b01, a[31] ^ b[31], 8'(e + 1), p[46:24]};
        return {2'b01, a[31] ^ b[31], 8'(e), p[45:23]};
    endfunction

    // Multiplier stand-in: LAT-deep pipe that freezes on stall.
    logic [W-1:0] mpipe [LAT];
    always @(posedge clk) begin
        if (!stall) begin
            for (int i = LAT - 1; i > 0; i--) mpipe[i] <= mpipe[i-1];
            mpipe[0] <= fpmul(mul_x, mul_y);
        end
    end
    assign mul_r = mpipe[LAT-1];

    // Reference model: in-flight queue in issue order; an entry is at the
    // consumer once it has seen LAT-1 advancing edges since issue.
    typedef struct { int idx; logic [W-1:0] data; int age; } ent_t;
    ent_t m_q[$];
    int   m_ptr;
    int   m_issued [NREQ];
    int   m_done   [NREQ];

    function automatic int m_grant();
        for (int k = 0; k < NREQ; k++) begin
            if (vld[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic bit m_at_tail();
        return (m_q.size() > 0) && (m_q[0].age == LAT - 1);
    endfunction

    function automatic bit m_hold();
        return m_at_tail() && !rdy[m_q[0].idx];
    endfunction

    function automatic logic [NREQ-1:0] m_ready();
        int g;
        g = m_grant();
        if (g < 0 || m_hold()) return '0;
        return NREQ'(1) << g;
    endfunction

    function automatic logic [NREQ-1:0] m_rsp();
        if (!m_at_tail()) return '0;
        return NREQ'(1) << m_q[0].idx;
    endfunction

    task automatic model_edge();
        int   g;
        ent_t e;
        g = m_grant();
        if (!m_hold()) begin
            if (m_at_tail()) void'(m_q.pop_front());
            for (int i = 0; i < m_q.size(); i++) m_q[i].age = m_q[i].age + 1;
            if (g >= 0) begin
                e.idx  = g;
                e.data = fpmul(xs[g*W +: W], ys[g*W +: W]);
                e.age  = 0;
                m_q.push_back(e);
                m_ptr = (g + 1) % NREQ;
                m_issued[g]++;
            end
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ptr = 0;
        for (int i = 0; i < NREQ; i++) begin
            m_issued[i] = 0;
            m_done[i]   = 0;
        end
    endtask

    // Called after the negedge checks: log observed completions, advance model, cross edge.
    task automatic step();
        for (int i = 0; i < NREQ; i++) if (rsp_valid[i] && rdy[i]) m_done[i]++;
        model_edge();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rnd_fp();
        return {2'b01, 1'($urandom_range(1, 0)), 8'($urandom_range(190, 64)), 23'($urandom)};
    endfunction

    task automatic rand_ops();
        for (int i = 0; i < NREQ; i++) begin
            xs[i*W +: W] = rnd_fp();
            ys[i*W +: W] = rnd_fp();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        vld   = '0;
        rdy   = '1;
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        vld = '1;
        rdy = '1;
        rand_ops();
        #1 rst_n = 1'b0;
        #2;
        total++; if (ready !== '0) begin bad++; $display("FAIL reset_ready: got %b want 0", ready); end
        total++; if (rsp_valid !== '0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", stall); end
        total++; if (inflight !== 2'd0) begin bad++; $display("FAIL reset_inflight: got %0d want 0", inflight); end
        total++; if (mul_x !== '0) begin bad++; $display("FAIL reset_mul_x: got %h want 0", mul_x); end
        total++; if (mul_y !== '0) begin bad++; $display("FAIL reset_mul_y: got %h want 0", mul_y); end
    endtask

    task automatic test_single_op();
        int peak;
        do_reset();
        vld = 4'b0100;
        xs[2*W +: W] = 34'h140400000;
        ys[2*W +: W] = 34'h143D80000;
        @(negedge clk);
        total++; if (ready !== 4'b0100) begin bad++; $display("FAIL single_ready: got %b want 0100", ready); end
        total++; if (mul_x !== 34'h140400000) begin bad++; $display("FAIL single_mul_x: got %h want 140400000", mul_x); end
        total++; if (mul_y !== 34'h143D80000) begin bad++; $display("FAIL single_mul_y: got %h want 143d80000", mul_y); end
        step();
        vld  = '0;
        peak = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            total++;
            if (rsp_valid !== ((k == 3) ? 4'b0100 : 4'b0000)) begin
                bad++; $display("FAIL single_rsp_valid k=%0d: got %b want %b", k, rsp_valid, (k == 3) ? 4'b0100 : 4'b0000);
            end
            if (k == 3) begin
                total++; if (rsp_data !== 34'h144A20000) begin bad++; $display("FAIL single_rsp_data: got %h want 144a20000", rsp_data); end
            end
            if (int'(inflight) > peak) peak = int'(inflight);
            step();
        end
        total++; if (peak != 1) begin bad++; $display("FAIL single_inflight_peak: got %0d want 1", peak); end
    endtask

    task automatic test_round_robin();
        logic [W-1:0]    ed [15];
        logic [NREQ-1:0] want;
        do_reset();
        rdy = '1;
        for (int c = 0; c < 15; c++) begin
            vld = (c < 12) ? '1 : '0;
            rand_ops();
            ed[c] = fpmul(xs[(c % 4)*W +: W], ys[(c % 4)*W +: W]);
            @(negedge clk);
            want = (c < 12) ? (NREQ'(1) << (c % 4)) : '0;
            total++; if (ready !== want) begin bad++; $display("FAIL rr_grant c=%0d: got %b want %b", c, ready, want); end
            if (c >= 3) begin
                want = NREQ'(1) << ((c - 3) % 4);
                total++; if (rsp_valid !== want) begin bad++; $display("FAIL rr_rsp_valid c=%0d: got %b want %b", c, rsp_valid, want); end
                total++; if (rsp_data !== ed[c-3]) begin bad++; $display("FAIL rr_rsp_data c=%0d: got %h want %h", c, rsp_data, ed[c-3]); end
            end
            step();
        end
    endtask

    task automatic test_back_pressure();
        logic [W-1:0] held;
        held = '0;
        do_reset();
        for (int c = 0; c < 20; c++) begin
            vld = (c < 14) ? '1 : '0;
            rdy = '1;
            if (c >= 4 && c < 9) rdy[1] = 1'b0;
            rand_ops();
            @(negedge clk);
            if (c == 4) held = rsp_data;
            total++; if (ready !== m_ready()) begin bad++; $display("FAIL bp_ready c=%0d: got %b want %b", c, ready, m_ready()); end
            total++; if (rsp_valid !== m_rsp()) begin bad++; $display("FAIL bp_rsp_valid c=%0d: got %b want %b", c, rsp_valid, m_rsp()); end
            if (m_at_tail()) begin
                total++; if (rsp_data !== m_q[0].data) begin bad++; $display("FAIL bp_rsp_data c=%0d: got %h want %h", c, rsp_data, m_q[0].data); end
            end
            if (c >= 4 && c < 9) begin
                total++; if (stall !== 1'b1) begin bad++; $display("FAIL bp_stall c=%0d: got %b want 1", c, stall); end
                total++; if (ready !== '0) begin bad++; $display("FAIL bp_ready_zero c=%0d: got %b want 0", c, ready); end
                total++; if (rsp_valid !== 4'b0010) begin bad++; $display("FAIL bp_hold_valid c=%0d: got %b want 0010", c, rsp_valid); end
                total++; if (rsp_data !== held) begin bad++; $display("FAIL bp_hold_data c=%0d: got %h want %h", c, rsp_data, held); end
            end else begin
                total++; if (stall !== 1'b0) begin bad++; $display("FAIL bp_nostall c=%0d: got %b want 0", c, stall); end
            end
            step();
        end
        vld = '0;
        rdy = '1;
        for (int n = 0; n < 8; n++) step();
        for (int i = 0; i < NREQ; i++) begin
            total++; if (m_done[i] != m_issued[i]) begin bad++; $display("FAIL bp_count req=%0d: got %0d want %0d", i, m_done[i], m_issued[i]); end
        end
    endtask

    task automatic test_sparse();
        logic [NREQ-1:0] want;
        do_reset();
        vld = 4'b0010;
        rand_ops();
        @(negedge clk);
        total++; if (ready !== 4'b0010) begin bad++; $display("FAIL sparse_prime: got %b want 0010", ready); end
        step();
        vld = 4'b1010;
        for (int c = 0; c < 4; c++) begin
            rand_ops();
            @(negedge clk);
            want = (c % 2 == 0) ? 4'b1000 : 4'b0010;
            total++; if (ready !== want) begin bad++; $display("FAIL sparse_grant c=%0d: got %b want %b", c, ready, want); end
            step();
        end
        vld = '0;
        for (int n = 0; n < 6; n++) step();
        total++; if (m_done[1] != 3 || m_done[3] != 2) begin bad++; $display("FAIL sparse_count: got r1=%0d r3=%0d want r1=3 r3=2", m_done[1], m_done[3]); end
    endtask

    task automatic test_async_reset();
        do_reset();
        vld = '1;
        for (int c = 0; c < 3; c++) begin
            rand_ops();
            step();
        end
        @(negedge clk);
        total++; if (inflight !== 2'd3) begin bad++; $display("FAIL ar_pre_inflight: got %0d want 3", inflight); end
        #1 rst_n = 1'b0;
        #1;
        total++; if (rsp_valid !== '0) begin bad++; $display("FAIL ar_rsp_valid: got %b want 0", rsp_valid); end
        total++; if (inflight !== 2'd0) begin bad++; $display("FAIL ar_inflight: got %0d want 0", inflight); end
        total++; if (ready !== '0) begin bad++; $display("FAIL ar_ready: got %b want 0", ready); end
        model_reset();
        vld = '0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int c = 0; c < 2 * LAT; c++) begin
            @(negedge clk);
            total++; if (rsp_valid !== '0 || inflight !== 2'd0) begin
                bad++; $display("FAIL ar_stale c=%0d: got valid=%b inflight=%0d want 0/0", c, rsp_valid, inflight);
            end
            step();
        end
    endtask

    task automatic test_random_soak();
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            vld = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) rdy[i] = ($urandom_range(3, 0) != 0);
            rand_ops();
            @(negedge clk);
            total++; if (ready !== m_ready()) begin bad++; $display("FAIL soak_ready c=%0d: got %b want %b", c, ready, m_ready()); end
            total++; if (stall !== m_hold()) begin bad++; $display("FAIL soak_stall c=%0d: got %b want %b", c, stall, m_hold()); end
            total++; if (rsp_valid !== m_rsp()) begin bad++; $display("FAIL soak_rsp_valid c=%0d: got %b want %b", c, rsp_valid, m_rsp()); end
            total++; if (inflight !== 2'(m_q.size())) begin bad++; $display("FAIL soak_inflight c=%0d: got %0d want %0d", c, inflight, m_q.size()); end
            if (m_at_tail()) begin
                total++; if (rsp_data !== m_q[0].data) begin bad++; $display("FAIL soak_rsp_data c=%0d: got %h want %h", c, rsp_data, m_q[0].data); end
            end
            if (m_grant() >= 0) begin
                total++; if (mul_x !== xs[m_grant()*W +: W]) begin bad++; $display("FAIL soak_mul_x c=%0d: got %h want %h", c, mul_x, xs[m_grant()*W +: W]); end
            end
            step();
        end
        vld = '0;
        rdy = '1;
        for (int n = 0; n < 8; n++) step();
        @(negedge clk);
        total++; if (inflight !== 2'd0) begin bad++; $display("FAIL soak_drain_inflight: got %0d want 0", inflight); end
        for (int i = 0; i < NREQ; i++) begin
            total++; if (m_done[i] != m_issued[i]) begin bad++; $display("FAIL soak_count req=%0d: got %0d want %0d", i, m_done[i], m_issued[i]); end
        end
    endtask

    initial begin
        vld = '0;
        rdy = '1;
        xs  = '0;
        ys  = '0;
        model_reset();
        test_reset();
        test_single_op();
        test_round_robin();
        test_back_pressure();
        test_sparse();
        test_async_reset();
        test_random_soak();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
